seq_shift_unit: RTL
===================

# seq_shift_unit

Parametrised multi-mode shifter for the ALU datapath. It replaces the fixed 4-bit combinational right shift with a registered, handshaked unit. It supports logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand. By default the shift is performed iteratively, one bit per clock, so that wide operands do not cost a full barrel network. A compile-time option swaps in a single-cycle barrel datapath behind the same interface.

## Interface
- WIDTH, 8, operand/result width; must be a power of two, at least 4.
- SHW, 4, shift-amount width; b ranges over 0..2^SHW-1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- a  input  WIDTH  operand.
- b  input  SHW  shift amount.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result register.
- busy  output  1  high in the SHIFT or DONE state.

## Operation
- **FSM states:** IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE:**
  - in_ready=1.
  - On in_valid&&in_ready, capture a into the work register, capture op, and load cnt with the effective amount n.
  - Next state is SHIFT if n>0, otherwise DONE.
- **Effective amount n:**
  - SLL/SRL/SRA: n=min(b, WIDTH).
  - ROR: n=b mod WIDTH.
  - cnt width is clog2(WIDTH)+1.
- **SHIFT:** each cycle:
  - Shift the work register one bit per op:
    - SLL: fill 0 at the LSB.
    - SRL: fill 0 at the MSB.
    - SRA: fill with the captured MSB.
    - ROR: old LSB goes to the MSB.
  - Decrement cnt.
  - When cnt==1, load the shifted value into out and go to DONE.
- **Saturation:** b≥WIDTH yields all zeros for SLL/SRL, and all copies of the sign bit for SRA.
- **DONE:**
  - out_valid=1.
  - Hold out and out_valid stable until out_ready=1, then go to IDLE.
  - in_ready=0.
- **out register:**
  - Written only when entering DONE.
  - Holds its value in IDLE and SHIFT; the previous result stays visible.
- **Inputs in SHIFT/DONE:** in_valid is ignored. No request is queued or dropped silently, because in_ready is low.
- **Ready independence:**
  - in_ready is a function of state only; there is no combinational path from out_ready to in_ready.
  - out_valid does not depend on out_ready.

## Timing
- **Reset values (while rst_n=0 and after release):**
  - state=IDLE, out=0, out_valid=0, busy=0, cnt=0, work register=0.
  - in_ready is forced 0 while rst_n=0 and is 1 from the first cycle after release.
- **Latency:**
  - Request accepted at the end of cycle 0 gives out_valid high in cycle n+1.
  - Examples: n=0 → cycle 1; b=3 SRL → cycle 4.
- **Throughput:** after the DONE handshake the unit spends one cycle in IDLE. Minimum issue interval is n+2 cycles.
- **Reset mid-operation:** asynchronous assertion in SHIFT or DONE immediately clears out_valid and busy. The in-flight result is lost. No output is produced after release.
- **op/b changing during SHIFT:** no effect; the captured values are used.

## Configuration
- **Macro:** SEQ_SHIFT_BARREL_EN.
- **Defined:**
  - The work register is replaced by a single-cycle log2(WIDTH)-stage barrel computing the full result at acceptance.
  - The SHIFT state is never entered. IDLE goes to DONE and out_valid rises in cycle 1 for every b.
  - Results, saturation rules and handshake are identical to the iterative mode.
- **Undefined:** iterative one-bit-per-cycle datapath as described above.

## Test plan
- **SRL:** op=01, a=8'hB4, b=3. Required: in_ready drops in cycle 1, out=8'h16 with out_valid high in cycle 4, busy high cycles 1–4.
- **SRA and ROR:**
  - op=10, a=8'hB4, b=2 gives out=8'hED in cycle 3.
  - op=11, a=8'hB4, b=12 gives effective n=4, out=8'h4B in cycle 5.
- **Saturation:**
  - op=00, a=8'hFF, b=9 gives n=8, out=8'h00 in cycle 9.
  - op=10, a=8'h80, b=15 gives out=8'hFF.
  - b=0 on any op gives out=a in cycle 1.
- **Backpressure:**
  - Hold out_ready=0 for 5 cycles after out_valid. out and out_valid must stay stable; in_ready=0; in_valid pulses are not accepted.
  - Release out_ready: IDLE and in_ready=1 on the next cycle.
- **Reset mid-SHIFT:**
  - Assert rst_n=0 in cycle 2 of a b=6 request. out=0 and out_valid=0 immediately.
  - After release, in_ready=1 and no stale out_valid appears.
- **SEQ_SHIFT_BARREL_EN build:** repeat the scenarios above. Every result must match, with out_valid in cycle 1 regardless of b.

Source files
------------

// File: rtl/seq_shift_if.sv
// seq_shift_if -- request/response bundle for seq_shift_unit.
//
// Parameters:
//   WIDTH : operand/result width
//   SHW   : shift-amount width
//
// Signals:
//   in_valid / in_ready   : request handshake (requester -> unit)
//   op, a, b              : operation code, operand, shift amount
//   out_valid / out_ready : result handshake (unit -> consumer)
//   out                   : result register of the unit
//   busy                  : unit is occupied with a request
//
// Modports:
//   master : requester/consumer side (testbench or ALU control)
//   slave  : the shift unit itself
interface seq_shift_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/seq_shift_unit.sv
// seq_shift_unit -- registered, handshaked multi-mode shifter.
//
// Operations (op): 00 SLL, 01 SRL, 10 SRA, 11 ROR on a WIDTH-bit operand.
// Shift amounts of WIDTH or more saturate for SLL/SRL/SRA (all zeros, or all
// sign bits for SRA); ROR uses the amount modulo WIDTH.
//
// Default build: iterative datapath, one bit per clock (IDLE -> SHIFT -> DONE).
// With SEQ_SHIFT_BARREL_EN defined: a single-cycle log2(WIDTH)-stage barrel
// computes the result at acceptance and the unit goes IDLE -> DONE directly.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_shift_if.slave (in_valid/in_ready, op, a, b,
//           out_valid/out_ready, out, busy)
module seq_shift_unit #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_shift_if.slave bus
);

  localparam int          LOG_W   = $clog2(WIDTH);
  localparam int          CNT_W   = LOG_W + 1;
  localparam int unsigned WIDTH_U = WIDTH;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load_out;
  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] out_q;
  logic [CNT_W-1:0] n_eff;

  // Effective shift amount: saturate at WIDTH for the linear shifts, wrap
  // modulo WIDTH for the rotate.
  function automatic logic [CNT_W-1:0] eff_amount(input logic [1:0]     op_i,
                                                  input logic [SHW-1:0] b_i);
    int unsigned bi;
    bi = 32'(b_i);
    if (op_i == 2'b11)
      return CNT_W'(bi % WIDTH_U);
    else if (bi >= WIDTH_U)
      return CNT_W'(WIDTH_U);
    else
      return CNT_W'(bi);
  endfunction

  assign n_eff   = eff_amount(bus.op, bus.b);
  assign bus.out = out_q;

`ifdef SEQ_SHIFT_BARREL_EN
  // Stage k shifts by 2^k when bit k of the amount is set. The top stage
  // (shift by WIDTH) only fires for saturated linear shifts and clears the
  // word, or fills it with the sign for SRA.
  function automatic logic [WIDTH-1:0] barrel(input logic [1:0]       op_i,
                                              input logic [WIDTH-1:0] x,
                                              input logic [CNT_W-1:0] n);
    logic        [WIDTH-1:0] v;
    logic signed [WIDTH-1:0] vs;
    v = x;
    for (int k = 0; k < CNT_W; k++) begin
      if (n[k]) begin
        vs = signed'(v);
        case (op_i)
          OP_SLL:  v = v << (1 << k);
          OP_SRL:  v = v >> (1 << k);
          OP_SRA:  v = unsigned'(vs >>> (1 << k));
          default: v = (v >> (1 << k)) | (v << (WIDTH - (1 << k)));
        endcase
      end
    end
    return v;
  endfunction
`else
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_shifted;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt;

  // One-bit step of the captured operation. SRA replicates the current MSB,
  // which equals the captured sign since SRA never changes it.
  function automatic logic [WIDTH-1:0] shift_one(input logic [1:0]       op_i,
                                                 input logic [WIDTH-1:0] x);
    logic signed [WIDTH-1:0] xs;
    xs = signed'(x);
    case (op_i)
      OP_SLL:  return {x[WIDTH-2:0], 1'b0};
      OP_SRL:  return {1'b0, x[WIDTH-1:1]};
      OP_SRA:  return unsigned'(xs >>> 1);
      default: return {x[0], x[WIDTH-1:1]};
    endcase
  endfunction

  assign work_shifted = shift_one(op_q, work);
`endif

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---- next state and handshake outputs ----
  always_comb begin
    state_nxt     = state;
    load_out      = 1'b0;
    out_nxt       = out_q;
    // in_ready depends on state only (plus reset), never on out_ready.
    bus.in_ready  = rst_n && (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef SEQ_SHIFT_BARREL_EN
          load_out  = 1'b1;
          out_nxt   = barrel(bus.op, bus.a, n_eff);
          state_nxt = DONE;
`else
          if (n_eff == '0) begin
            load_out  = 1'b1;
            out_nxt   = bus.a;
            state_nxt = DONE;
          end else begin
            state_nxt = SHIFT;
          end
`endif
        end
      end
      SHIFT: begin
`ifdef SEQ_SHIFT_BARREL_EN
        state_nxt = IDLE;
`else
        // Last step: the shifted value is the result.
        if (cnt == CNT_W'(1)) begin
          load_out  = 1'b1;
          out_nxt   = work_shifted;
          state_nxt = DONE;
        end
`endif
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- result and work registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
`ifndef SEQ_SHIFT_BARREL_EN
      work  <= '0;
      op_q  <= '0;
      cnt   <= '0;
`endif
    end else begin
      if (load_out) out_q <= out_nxt;
`ifndef SEQ_SHIFT_BARREL_EN
      if (state == IDLE && bus.in_valid) begin
        work <= bus.a;
        op_q <= bus.op;
        cnt  <= n_eff;
      end else if (state == SHIFT) begin
        work <= work_shifted;
        cnt  <= cnt - CNT_W'(1);
      end
`endif
    end
  end

endmodule
